// File: rtl/add_sub_writeback_if.sv
// Result handshake and write-port bundle for the add/sub writeback stage.
// The master side produces results and grants; the slave side is the writeback stage.
interface add_sub_writeback_if #(
  parameter int unsigned RS_ID_WIDTH = 5
);

  typedef struct packed {
    logic [31:0] xer;
    logic        so;
    logic        xer_valid;
    logic        cr0_valid;
  } cond_exception_t;

  // Execution-unit result handshake
  logic                   in_valid;
  logic                   in_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_in;
  logic [4:0]             result_reg_addr_in;
  logic [0:31]            result_in;  // bit 0 is the MSB
  cond_exception_t        cr0_xer_in;

  // Shared write-port arbitration
  logic                   wb_req;
  logic                   wb_grant;

  // Retire outputs
  logic                   gpr_we;
  logic [4:0]             gpr_addr;
  logic [0:31]            gpr_data;
  logic                   cr0_we;
  logic [3:0]             cr0_data;
  logic                   xer_we;
  logic [31:0]            xer_data;
  logic                   done_valid;
  logic [RS_ID_WIDTH-1:0] done_rs_id;

  modport master (
    output in_valid,
    output rs_id_in,
    output result_reg_addr_in,
    output result_in,
    output cr0_xer_in,
    output wb_grant,
    input  in_ready,
    input  wb_req,
    input  gpr_we,
    input  gpr_addr,
    input  gpr_data,
    input  cr0_we,
    input  cr0_data,
    input  xer_we,
    input  xer_data,
    input  done_valid,
    input  done_rs_id
  );

  modport slave (
    input  in_valid,
    input  rs_id_in,
    input  result_reg_addr_in,
    input  result_in,
    input  cr0_xer_in,
    input  wb_grant,
    output in_ready,
    output wb_req,
    output gpr_we,
    output gpr_addr,
    output gpr_data,
    output cr0_we,
    output cr0_data,
    output xer_we,
    output xer_data,
    output done_valid,
    output done_rs_id
  );

endinterface

// File: rtl/add_sub_writeback.sv
// Writeback stage: FIFO-buffers add/sub results and retires one per granted write-port cycle.
// Define ADD_SUB_WB_BYPASS_EN to let an empty FIFO retire the incoming result in the same cycle.
module add_sub_writeback #(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned DEPTH       = 4
) (
  input logic                clk,
  input logic                rst,
  add_sub_writeback_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  // Entry storage, one array per field
  logic [RS_ID_WIDTH-1:0] rs_id_mem  [DEPTH];
  logic [4:0]             addr_mem   [DEPTH];
  logic [0:31]            result_mem [DEPTH];
  logic [31:0]            xer_mem    [DEPTH];
  logic                   so_mem     [DEPTH];
  logic                   xer_vld_mem[DEPTH];
  logic                   cr0_vld_mem[DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic fifo_nonempty;
  logic fifo_full;
  logic bypass_take;
  logic push;
  logic pop;
  logic wb_req;
  logic fire;

  // Head view: FIFO head, or the live input when bypassing an empty FIFO
  logic                   head_valid;
  logic [RS_ID_WIDTH-1:0] head_rs_id;
  logic [4:0]             head_addr;
  logic [0:31]            head_result;
  logic [31:0]            head_xer;
  logic                   head_so;
  logic                   head_xer_vld;
  logic                   head_cr0_vld;

  logic       cr0_lt;
  logic       cr0_gt;
  logic       cr0_eq;
  logic [3:0] cr0_vec;

  assign fifo_nonempty = (count_q != '0);
  assign fifo_full     = (count_q == FullCnt);

  always_comb begin
    head_valid   = fifo_nonempty;
    head_rs_id   = rs_id_mem[rd_ptr_q];
    head_addr    = addr_mem[rd_ptr_q];
    head_result  = result_mem[rd_ptr_q];
    head_xer     = xer_mem[rd_ptr_q];
    head_so      = so_mem[rd_ptr_q];
    head_xer_vld = xer_vld_mem[rd_ptr_q];
    head_cr0_vld = cr0_vld_mem[rd_ptr_q];
`ifdef ADD_SUB_WB_BYPASS_EN
    if (!fifo_nonempty && bus.in_valid) begin
      head_valid   = 1'b1;
      head_rs_id   = bus.rs_id_in;
      head_addr    = bus.result_reg_addr_in;
      head_result  = bus.result_in;
      head_xer     = bus.cr0_xer_in.xer;
      head_so      = bus.cr0_xer_in.so;
      head_xer_vld = bus.cr0_xer_in.xer_valid;
      head_cr0_vld = bus.cr0_xer_in.cr0_valid;
    end
`endif
  end

`ifdef ADD_SUB_WB_BYPASS_EN
  // A granted bypass retires straight from the input and never touches storage
  assign bypass_take = !fifo_nonempty && bus.in_valid && bus.wb_grant;
`else
  assign bypass_take = 1'b0;
`endif

  assign wb_req = head_valid;
  assign fire   = wb_req & bus.wb_grant;
  assign push   = bus.in_valid & ~fifo_full & ~bypass_take;
  assign pop    = fifo_nonempty & bus.wb_grant;

  // Signed compare against zero; bit 0 is the sign bit
  always_comb begin
    cr0_lt  = head_result[0];
    cr0_eq  = (head_result == '0);
    cr0_gt  = ~head_result[0] & ~cr0_eq;
    cr0_vec = {cr0_lt, cr0_gt, cr0_eq, head_so};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read as valid
  always_ff @(posedge clk) begin
    if (push) begin
      rs_id_mem[wr_ptr_q]   <= bus.rs_id_in;
      addr_mem[wr_ptr_q]    <= bus.result_reg_addr_in;
      result_mem[wr_ptr_q]  <= bus.result_in;
      xer_mem[wr_ptr_q]     <= bus.cr0_xer_in.xer;
      so_mem[wr_ptr_q]      <= bus.cr0_xer_in.so;
      xer_vld_mem[wr_ptr_q] <= bus.cr0_xer_in.xer_valid;
      cr0_vld_mem[wr_ptr_q] <= bus.cr0_xer_in.cr0_valid;
    end
  end

  assign bus.in_ready = ~fifo_full;
  assign bus.wb_req   = wb_req;

  always_comb begin
    bus.gpr_we     = fire;
    bus.cr0_we     = fire & head_cr0_vld;
    bus.xer_we     = fire & head_xer_vld;
    bus.done_valid = fire;
    bus.gpr_addr   = '0;
    bus.gpr_data   = '0;
    bus.cr0_data   = '0;
    bus.xer_data   = '0;
    bus.done_rs_id = '0;
    if (wb_req) begin
      bus.gpr_addr   = head_addr;
      bus.gpr_data   = head_result;
      bus.cr0_data   = cr0_vec;
      bus.xer_data   = head_xer;
      bus.done_rs_id = head_rs_id;
    end
  end

endmodule

// File: tb/tb_add_sub_writeback.sv
// Self-checking bench for add_sub_writeback: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_add_sub_writeback;

  localparam int unsigned RsW   = 5;
  localparam int unsigned Depth = 4;
`ifdef ADD_SUB_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic [RsW-1:0] rs_id;
    logic [4:0]     addr;
    logic [31:0]    result;
    logic [31:0]    xer;
    logic           so;
    logic           xv;
    logic           cv;
  } ent_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  ent_t q[$];
  ent_t cur_in;
  int   fires;

  add_sub_writeback_if #(.RS_ID_WIDTH(RsW)) bus ();

  add_sub_writeback #(
    .RS_ID_WIDTH(RsW),
    .DEPTH      (Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // CR0 from the architectural meaning: signed comparison of the result with zero
  function automatic logic [3:0] exp_cr0(logic [31:0] r, logic so);
    int s;
    s = $signed(r);
    return {s < 0, s > 0, s == 0, so};
  endfunction

  function automatic ent_t mk(int id, int addr, logic [31:0] r, logic so, logic xv, logic cv,
                              logic [31:0] xer);
    ent_t e;
    e.rs_id  = RsW'(id);
    e.addr   = 5'(addr);
    e.result = r;
    e.xer    = xer;
    e.so     = so;
    e.xv     = xv;
    e.cv     = cv;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h0;
      1:       r = 32'h8000_0000 | 32'($urandom);
      default: r = 32'($urandom);
    endcase
    return mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), r, 1'($urandom),
              1'($urandom), 1'($urandom), 32'($urandom));
  endfunction

  task automatic set_in(ent_t e, bit v, bit g);
    cur_in                     = e;
    bus.in_valid               = v;
    bus.wb_grant               = g;
    bus.rs_id_in               = e.rs_id;
    bus.result_reg_addr_in     = e.addr;
    bus.result_in              = e.result;
    bus.cr0_xer_in.xer         = e.xer;
    bus.cr0_xer_in.so          = e.so;
    bus.cr0_xer_in.xer_valid   = e.xv;
    bus.cr0_xer_in.cr0_valid   = e.cv;
  endtask

  // Compare every DUT output with what the model's queue says it must be this cycle
  task automatic compare_now();
    ent_t h;
    bit   req;
    bit   fire;
    #1;
    req  = (q.size() != 0) || (Byp && bus.in_valid);
    h    = (q.size() != 0) ? q[0] : cur_in;
    fire = req && bus.wb_grant;
    chk("in_ready", bus.in_ready, q.size() != Depth);
    chk("wb_req", bus.wb_req, req);
    chk("gpr_we", bus.gpr_we, fire);
    chk("cr0_we", bus.cr0_we, fire && h.cv);
    chk("xer_we", bus.xer_we, fire && h.xv);
    chk("done_valid", bus.done_valid, fire);
    chk("gpr_addr", bus.gpr_addr, req ? h.addr : 5'd0);
    chk("gpr_data", bus.gpr_data, req ? h.result : 32'd0);
    chk("cr0_data", bus.cr0_data, req ? exp_cr0(h.result, h.so) : 4'd0);
    chk("xer_data", bus.xer_data, req ? h.xer : 32'd0);
    chk("done_rs_id", bus.done_rs_id, req ? h.rs_id : '0);
  endtask

  task automatic advance();
    bit byp_take;
    bit push;
    bit pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      byp_take = Byp && (q.size() == 0) && bus.in_valid && bus.wb_grant;
      pop      = (q.size() != 0) && bus.wb_grant;
      push     = bus.in_valid && (q.size() != Depth) && !byp_take;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cur_in);
    end
    @(negedge clk);
  endtask

  task automatic lit_zero();
    chk("zero.gpr_we", bus.gpr_we, 1'b1);
    chk("zero.gpr_addr", bus.gpr_addr, 5'd7);
    chk("zero.gpr_data", bus.gpr_data, 32'd0);
    chk("zero.cr0_we", bus.cr0_we, 1'b1);
    chk("zero.cr0_data", bus.cr0_data, 4'b0011);
    chk("zero.xer_we", bus.xer_we, 1'b0);
    chk("zero.done_rs_id", bus.done_rs_id, 5'd3);
  endtask

  ent_t idle;
  ent_t e;

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle        = mk(0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset with a result offered throughout; it must never retire
    rst = 1'b1;
    set_in(mk(9, 9, 32'h1234, 1'b1, 1'b1, 1'b1, 32'h55), 1'b1, 1'b1);
    advance();
    advance();
    rst = 1'b0;
    set_in(idle, 1'b0, 1'b1);
    compare_now();
    chk("rst.in_ready", bus.in_ready, 1'b1);
    chk("rst.wb_req", bus.wb_req, 1'b0);
    chk("rst.gpr_we", bus.gpr_we, 1'b0);
    advance();

    // Zero result: CR0 = EQ|SO
    set_in(mk(3, 7, 32'h0, 1'b1, 1'b0, 1'b1, 32'hABCD), 1'b1, 1'b1);
    compare_now();
`ifdef ADD_SUB_WB_BYPASS_EN
    lit_zero();
`endif
    advance();
    set_in(idle, 1'b0, 1'b1);
    compare_now();
`ifndef ADD_SUB_WB_BYPASS_EN
    lit_zero();
`endif
    advance();

    // Negative then positive, retired in order
    set_in(mk(1, 2, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1, 1'b0);
    compare_now();
    advance();
    set_in(mk(2, 3, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1, 1'b0);
    compare_now();
    advance();
    set_in(idle, 1'b0, 1'b1);
    compare_now();
    chk("neg.cr0_data", bus.cr0_data, 4'b1000);
    advance();
    compare_now();
    chk("pos.cr0_data", bus.cr0_data, 4'b0100);
    advance();

    // Fill to DEPTH with grant low
    for (int i = 0; i < Depth; i++) begin
      set_in(mk(10 + i, i, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0, 32'(i)), 1'b1, 1'b0);
      compare_now();
      advance();
    end
    set_in(mk(20, 20, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 1'b0);
    compare_now();
    chk("full.in_ready", bus.in_ready, 1'b0);
    advance();
    set_in(mk(20, 20, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 1'b1);
    compare_now();
    chk("full.pop_head", bus.gpr_data, 32'h100);
    chk("full.no_accept", bus.in_ready, 1'b0);
    advance();
    set_in(idle, 1'b0, 1'b0);
    compare_now();
    chk("full.ready_back", bus.in_ready, 1'b1);
    advance();
    for (int i = 0; i < Depth; i++) begin
      set_in(idle, 1'b0, 1'b1);
      compare_now();
      advance();
    end

    // Simultaneous push/pop holding count at 2
    for (int i = 0; i < 2; i++) begin
      set_in(mk(i, i, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b1, 32'h0), 1'b1, 1'b0);
      compare_now();
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(mk(5 + i, 5 + i, 32'h300 + 32'(i), 1'b0, 1'b1, 1'b1, 32'h7), 1'b1, 1'b1);
      compare_now();
      chk("pp.gpr_we", bus.gpr_we, 1'b1);
      chk("pp.in_ready", bus.in_ready, 1'b1);
      advance();
    end
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(idle, 1'b0, 1'b1);
      compare_now();
      if (bus.gpr_we === 1'b1) fires++;
      advance();
    end
    chk("pp.remaining", 64'(fires), 64'd2);

`ifdef ADD_SUB_WB_BYPASS_EN
    // Bypass retires from an empty FIFO in the same cycle
    set_in(mk(4, 4, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0), 1'b1, 1'b1);
    compare_now();
    chk("byp.gpr_we", bus.gpr_we, 1'b1);
    chk("byp.cr0_data", bus.cr0_data, 4'b0100);
    advance();
    set_in(idle, 1'b0, 1'b1);
    compare_now();
    chk("byp.empty", bus.wb_req, 1'b0);
    advance();
`endif

    // Random traffic at three grant densities, with rare mid-stream resets
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 300; i++) begin
        rst = ($urandom_range(0, 99) == 0);
        e   = rand_ent();
        set_in(e, ($urandom_range(0, 3) != 0),
               (phase == 0) ? ($urandom_range(0, 3) == 0) :
               (phase == 1) ? 1'($urandom) : ($urandom_range(0, 9) != 0));
        compare_now();
        advance();
      end
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_sub_writeback.md
# add_sub_writeback

Writeback stage sitting at the output end of the add/sub execution unit. It accepts completed results over the unit's valid/ready result handshake and buffers them in a small FIFO. It arbitrates for the shared GPR/CR/XER write port through a req/grant pair, and on each granted cycle retires one entry. Retiring means writing the GPR, optionally writing CR0 (derived from the result) and XER, and signalling completion of the reservation-station ID.

## Interface
- RS_ID_WIDTH, 5, width of reservation-station ID
- DEPTH, 4, FIFO entries; power of two, >= 2
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  result offered by execution unit
- in_ready  out  1  entry can be accepted
- rs_id_in  in  RS_ID_WIDTH  ID of producing instruction
- result_reg_addr_in  in  5  destination GPR
- result_in  in  32  result value, bit 0 = MSB
- cr0_xer_in  in  cond_exception_t  XER value, so, xer_valid, CR0_valid
- wb_req  out  1  head entry wants the write port
- wb_grant  in  1  write port granted this cycle
- gpr_we  out  1  GPR write strobe
- gpr_addr  out  5  GPR address
- gpr_data  out  32  GPR data
- cr0_we  out  1  CR0 write strobe
- cr0_data  out  4  {LT, GT, EQ, SO}
- xer_we  out  1  XER write strobe
- xer_data  out  32  XER value
- done_valid  out  1  completion pulse
- done_rs_id  out  RS_ID_WIDTH  completed ID

## Operation
- State: DEPTH-entry storage holding {rs_id, reg addr, result, cr0_xer}, write and read pointers of log2(DEPTH) bits each (natural wrap), and a count of $clog2(DEPTH+1) bits.
- Push: `in_valid & in_ready` at a clock edge writes the entry at the write pointer. The write pointer is incremented.
- `in_ready = (count != DEPTH)`. It does not depend on `wb_grant`, so there is no combinational grant-to-ready path. When the FIFO is full it cannot accept in the same cycle it pops.
- `wb_req = (count != 0)`.
- Pop: `wb_req & wb_grant` at an edge advances the read pointer. A simultaneous push and pop leaves count unchanged.
- Retire outputs are combinational from the head entry and are qualified by `fire = wb_req & wb_grant`:
  - gpr_we = fire.
  - cr0_we = fire & CR0_valid.
  - xer_we = fire & xer_valid.
  - done_valid = fire.
- Data outputs (gpr_addr, gpr_data, cr0_data, xer_data, done_rs_id) are forced to 0 when `wb_req` is low. Otherwise they carry head values.
- CR0 derivation from result r, with signed compare against zero:
  - LT = r[0].
  - GT = ~r[0] & (r != 0).
  - EQ = (r == 0).
  - SO = cr0_xer.so.
- Entries retire strictly in arrival order.
- `wb_grant` while `wb_req` is low is ignored.

## Timing
- Reset: count = 0 and pointers = 0. This gives wb_req = 0, all strobes = 0, all data outputs = 0, and in_ready = 1 from the first cycle after reset.
- During an `rst` cycle, pushes and pops are discarded.
- Reset mid-operation drops all buffered entries with no retire.
- Latency without bypass: an entry accepted at edge N is visible at the head, with wb_req high, in the cycle after N. The earliest retire is at edge N+1.
- Throughput: one push and one pop per cycle when count is in 1..DEPTH-1.
- Full (count = DEPTH): in_ready is low. After a pop, in_ready rises in the next cycle.
- Empty: wb_req is low and strobes are low, regardless of `wb_grant`.

## Configuration
- `ADD_SUB_WB_BYPASS_EN` defined: when count = 0 and `in_valid` is high, the following happen in the same cycle:
  - wb_req and the retire outputs are driven combinationally from the input fields.
  - If `wb_grant` is also high, the entry retires immediately and is not written to storage. The pointers and count are unchanged.
  - If `wb_grant` is low, the entry is pushed normally.
  - in_ready is unchanged.
- Not defined: no bypass. wb_req is strictly `count != 0` and the minimum latency is as given in Timing.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 -> after release, count = 0, in_ready = 1, wb_req = 0, all strobes and data = 0. No retire ever occurs for the input offered during reset.
- Zero result, no bypass: push {rs_id 3, reg 7, result 0x00000000, CR0_valid = 1, so = 1, xer_valid = 0}, with grant held high -> the next cycle shows gpr_we = 1, gpr_addr = 7, gpr_data = 0, cr0_we = 1, cr0_data = 4'b0011, xer_we = 0, done_rs_id = 3.
- Negative and positive results: push 0x80000000 then 0x00000005, both with CR0_valid = 1 and so = 0 -> they retire in order with cr0_data 4'b1000 then 4'b0100.
- Full: with grant low, push DEPTH entries -> in_ready falls after the DEPTH-th accept. Raise grant for one cycle -> one pop, and in_ready is 1 the following cycle. Entries drain in FIFO order.
- Simultaneous push/pop: with count = 2, hold in_valid and grant high for 5 cycles -> count stays 2 and 5 entries retire in order.
- With `ADD_SUB_WB_BYPASS_EN`: empty FIFO, in_valid = 1 with result 0x00000001 and wb_grant = 1 in the same cycle -> gpr_we = 1 and cr0_data = 4'b0100 in that cycle, and count remains 0.
